// File: rtl/rom_loader_if.sv
// ---------------------------------------------------------------------------
// rom_loader_if
// Byte-stream input and instruction-RAM write port of the boot loader.
//   rx_valid / rx_data / rx_ready : byte handshake from the host link
//   wr_en / wr_addr / wr_data     : write strobe into the instruction RAM
// Modports:
//   master : the loader (accepts bytes, drives RAM writes)
//   slave  : the host link and RAM side
// ---------------------------------------------------------------------------
interface rom_loader_if #(
  parameter int ADDR_W = 15
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader
// Boot-time program loader for the Hack instruction memory. Receives a byte
// stream (big-endian word count N, N instruction words, optional checksum),
// writes the words sequentially into instruction RAM from address 0 and holds
// the CPU in reset until the image is complete.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : rom_loader_if.master (rx_* byte handshake, wr_* RAM write)
//   load_req   : single-cycle pulse, restarts loading from DONE or ERR
//   cpu_reset  : high while the CPU must stay in reset (all states but DONE)
//   done       : image loaded, CPU released
//   err        : load aborted (oversized image or checksum mismatch)
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to require a trailing
// 16-bit checksum (sum of all data words modulo 2^16) before DONE.
// ---------------------------------------------------------------------------
module rom_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_loader_if.master bus,
  input  logic         load_req,
  output logic         cpu_reset,
  output logic         done,
  output logic         err
);

`ifdef ROM_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO,
    S_CSUM_HI, S_CSUM_LO, S_FINISH, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO,
    S_FINISH, S_DONE, S_ERR
  } state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        hi_byte;
  logic [15:0]       remain;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic [15:0]       rx_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       acc;
`endif

  assign accept  = bus.rx_valid && bus.rx_ready;
  // Every *_LO state sees the full big-endian word on the accepting cycle.
  assign rx_word = {hi_byte, bus.rx_data};

  function automatic logic ready_of(input state_t s);
    case (s)
      S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO: ready_of = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CSUM_HI, S_CSUM_LO:                     ready_of = 1'b1;
`endif
      default:                                  ready_of = 1'b0;
    endcase
  endfunction

  // S_FINISH inserts the cycle that lets the last RAM write land before the
  // CPU leaves reset; with the checksum compiled in the CSUM states do that.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = S_HDR_HI;
      S_HDR_HI:  if (accept) state_nxt = S_HDR_LO;
      S_HDR_LO:  if (accept) begin
        if (rx_word == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM_HI;
`else
          state_nxt = S_FINISH;
`endif
        end else if (int'(rx_word) > MAX_WORDS) begin
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
      S_DATA_LO: if (accept) begin
        if (remain == 16'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM_HI;
`else
          state_nxt = S_FINISH;
`endif
        end else begin
          state_nxt = S_DATA_HI;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CSUM_HI: if (accept) state_nxt = S_CSUM_LO;
      S_CSUM_LO: if (accept) state_nxt = (rx_word == acc) ? S_DONE : S_ERR;
`endif
      S_FINISH:  state_nxt = S_DONE;
      S_DONE,
      S_ERR:     if (load_req) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Control state and registered outputs; outputs are decoded from the next
  // state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bus.rx_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.rx_ready <= ready_of(state_nxt);
      cpu_reset    <= (state_nxt != S_DONE);
      done         <= (state_nxt == S_DONE);
      err          <= (state_nxt == S_ERR);
      bus.wr_en    <= (state == S_DATA_LO) && accept;
      if ((state == S_DATA_LO) && accept) begin
        bus.wr_addr <= idx;
        bus.wr_data <= rx_word;
      end
    end
  end

  // Datapath: byte assembly, word index, remaining count and checksum.
  // These are always (re)initialised in HDR_* before use, so no reset.
  always_ff @(posedge clk) begin
    if (accept) hi_byte <= bus.rx_data;

    if (state == S_HDR_HI) begin
      idx <= '0;
    end else if ((state == S_DATA_LO) && accept) begin
      idx <= idx + ADDR_W'(1);
    end

    if ((state == S_HDR_LO) && accept) begin
      remain <= rx_word;
    end else if ((state == S_DATA_LO) && accept) begin
      remain <= remain - 16'd1;
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    if (state == S_HDR_HI) begin
      acc <= 16'd0;
    end else if ((state == S_DATA_LO) && accept) begin
      acc <= acc + rx_word;
    end
`endif
  end

endmodule

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
module tb_rom_loader;
  localparam int ADDR_W    = 15;
  localparam int MAX_WORDS = 32768;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_req = 1'b0;
  logic cpu_reset, done, err;

  rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rom_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .load_req  (load_req),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM-side monitor: every write strobe with the cycle it was seen in.
  wr_t wr_log[$];
  wr_t mon_w;
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      mon_w.addr = int'(bus.wr_addr);
      mon_w.data = int'(bus.wr_data);
      mon_w.cyc  = cyc;
      wr_log.push_back(mon_w);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: decodes a stream straight from the format rules.
  int exp_addr[$];
  int exp_data[$];
  bit exp_err;
  int exp_cons;
  int exp_lat;

  task automatic model_image(input bq_t s);
    int n;
    int sum;
    int w;
    exp_addr.delete();
    exp_data.delete();
    n   = int'({s[0], s[1]});
    sum = 0;
    if (n > MAX_WORDS) begin
      exp_err  = 1'b1;
      exp_cons = 2;
      exp_lat  = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = int'({s[2+2*i], s[3+2*i]});
      exp_addr.push_back(i);
      exp_data.push_back(w);
      sum = (sum + w) % 65536;
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    exp_cons = 2 + 2*n + 2;
    exp_lat  = 0;
    exp_err  = (int'({s[2+2*n], s[3+2*n]}) != sum);
`else
    exp_cons = 2 + 2*n;
    exp_lat  = 1;
    exp_err  = 1'b0;
`endif
  endtask

  task automatic build_image(input int n, input bit bad, output bq_t s);
    int sum;
    logic [15:0] w;
    logic [15:0] nn;
    logic [15:0] cs;
    s.delete();
    nn = 16'(n);
    s.push_back(nn[15:8]);
    s.push_back(nn[7:0]);
    if (n > MAX_WORDS) return;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
      sum = (sum + int'(w)) % 65536;
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    cs = 16'(sum + (bad ? 1 : 0));
    s.push_back(cs[15:8]);
    s.push_back(cs[7:0]);
`else
    cs = 16'(bad);
`endif
  endtask

  // Presents cnt bytes with random idle gaps; hs_cyc is the cycle of the
  // final accepting edge. Returns at the negedge following that edge.
  task automatic send_bytes(input bq_t s, input int cnt, input int gap_pct,
                            output int hs_cyc, output bit ok);
    int  waited;
    bit  acc;
    ok     = 1'b1;
    hs_cyc = cyc;
    for (int i = 0; i < cnt; i++) begin
      waited = 0;
      acc    = 1'b0;
      while (!acc) begin
        @(negedge clk);
        if (int'($urandom_range(99)) < gap_pct) begin
          bus.rx_valid = 1'b0;
          bus.rx_data  = 8'($urandom);
        end else begin
          bus.rx_valid = 1'b1;
          bus.rx_data  = s[i];
        end
        acc = bus.rx_valid && bus.rx_ready;
        if (acc) hs_cyc = cyc + 1;
        waited++;
        if (!acc && waited > 200) begin
          check("rx_ready_timeout", 32'(0), 32'(1));
          ok = 1'b0;
          bus.rx_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_image(input string tag, input bq_t s, input int gap_pct);
    int hs;
    bit ok;
    int w;
    int st_cyc;
    model_image(s);
    wr_log.delete();
    send_bytes(s, exp_cons, gap_pct, hs, ok);
    if (!ok) return;
    w = 0;
    while (!(done || err) && w < 20) begin
      @(negedge clk);
      w++;
    end
    st_cyc = cyc;
    #1;
    check({tag, "_terminated"}, 32'(done || err), 32'(1));
    check({tag, "_latency"}, st_cyc - hs, exp_lat);
    check({tag, "_done"}, 32'(done), 32'(!exp_err));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(0));
    check({tag, "_nwrites"}, wr_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_log.size(); i++) begin
      check({tag, "_waddr"}, wr_log[i].addr, exp_addr[i]);
      check({tag, "_wdata"}, wr_log[i].data, exp_data[i]);
    end
    if (wr_log.size() > 0 && exp_addr.size() > 0) begin
      check({tag, "_wr_en_low"}, 32'(bus.wr_en), 32'(0));
      check({tag, "_addr_hold"}, 32'(bus.wr_addr), exp_addr[exp_addr.size()-1]);
      check({tag, "_data_hold"}, 32'(bus.wr_data), exp_data[exp_data.size()-1]);
`ifndef ROM_LOADER_CHECKSUM_EN
      check({tag, "_wr_to_done"}, st_cyc - wr_log[wr_log.size()-1].cyc, 1);
`endif
    end
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("reload_cpu_reset", 32'(cpu_reset), 32'(1));
    check("reload_done", 32'(done), 32'(0));
    check("reload_err", 32'(err), 32'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(0));
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'(0));
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(0));
    check({tag, "_wr_data"}, 32'(bus.wr_data), 32'(0));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(1));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    int  hs;
    bit  ok;
    int  nw;
    int  n;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hdr_ready", 32'(bus.rx_ready), 32'(1));

    // Directed three-word image
    s = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h00, 8'h07};
`ifdef ROM_LOADER_CHECKSUM_EN
    s.push_back(8'hEC);
    s.push_back(8'h1C);
`endif
    run_image("plan", s, 0);
    if (wr_log.size() == 3) begin
      check("plan_w1_const", wr_log[1].data, 32'h0000EC10);
      check("plan_w2_addr_const", wr_log[2].addr, 2);
    end else begin
      check("plan_three_writes", wr_log.size(), 3);
    end

    // Bytes offered while DONE are ignored
    nw = wr_log.size();
    repeat (20) begin
      @(negedge clk);
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
      if (bus.rx_ready || !done || bus.wr_en) check("done_hold", 32'(0), 32'(1));
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("done_still", 32'(done), 32'(1));
    check("done_no_writes", wr_log.size(), nw);

    // Empty image
    pulse_load();
    s = '{8'h00, 8'h00};
`ifdef ROM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
    s.push_back(8'h00);
`endif
    run_image("empty", s, 0);

    // Oversized header
    pulse_load();
    s = '{8'h80, 8'h01};
    run_image("oversize", s, 0);

`ifdef ROM_LOADER_CHECKSUM_EN
    pulse_load();
    s = '{8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'hEC, 8'h15};
    run_image("csum_good", s, 0);
    check("csum_good_const", 32'(done), 32'(1));
    pulse_load();
    s = '{8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'hEC, 8'h16};
    run_image("csum_bad", s, 0);
    check("csum_bad_const", 32'(err), 32'(1));
    check("csum_bad_writes", wr_log.size(), 2);
`endif

    // Randomised images, random gaps, occasional oversize / bad checksum
    for (int k = 0; k < 30; k++) begin
      pulse_load();
      if ($urandom_range(7) == 0) n = int'($urandom_range(65535, MAX_WORDS + 1));
      else n = int'($urandom_range(12));
      build_image(n, 1'($urandom), s);
      run_image("rand", s, int'($urandom_range(50)));
    end

    // Reset in the middle of a five-word load
    pulse_load();
    build_image(5, 1'b0, s);
    send_bytes(s, 6, 0, hs, ok);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    check("midreset_hold_cpu_reset", 32'(cpu_reset), 32'(1));
    rst_n = 1'b1;
    build_image(4, 1'b0, s);
    run_image("after_reset", s, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader for the Hack instruction memory. It receives a byte stream from a host link such as a UART receiver, assembles big-endian 16-bit instruction words, and writes them sequentially into the instruction RAM that the CPU later fetches from through the `address`/`data` read port. The CPU is held in reset until the image is loaded completely and, optionally, verified.

## Interface

Parameters:
- `ADDR_W`, default 15: instruction address width.
- `MAX_WORDS`, default 32768: largest accepted image size, in words. Must be ≤ 2^ADDR_W.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx_valid`, in, 1: an input byte is present.
- `rx_data`, in, 8: input byte.
- `rx_ready`, out, 1: loader accepts a byte this cycle.
- `load_req`, in, 1: single-cycle pulse; restarts loading from DONE or ERR.
- `wr_en`, out, 1: instruction RAM write strobe.
- `wr_addr`, out, ADDR_W: write address.
- `wr_data`, out, 16: write word.
- `cpu_reset`, out, 1: holds the CPU in reset while high.
- `done`, out, 1: image loaded and the CPU released.
- `err`, out, 1: load aborted.

## Operation

- A byte is accepted on any cycle where `rx_valid && rx_ready`. Bytes presented while `rx_ready` is 0 are ignored.
- Stream format, all fields big-endian (high byte first):
  - 16-bit word count N.
  - N 16-bit instruction words.
  - A 16-bit checksum, only when the checksum feature is enabled (see Configuration).
- States:
  - IDLE → HDR_HI → HDR_LO → DATA_HI → DATA_LO → (CSUM_HI → CSUM_LO) → DONE.
  - Any state can also move to ERR.
- `rx_ready` is 1 only in HDR_*, DATA_* and CSUM_*. It is 0 in IDLE, DONE and ERR.
- IDLE: entered on reset, and on `load_req` from DONE or ERR. It always advances to HDR_HI on the next cycle.
- HDR_LO accept:
  - N == 0: go to DONE (or to CSUM_HI when the checksum is compiled in).
  - N > MAX_WORDS: go to ERR. No RAM write occurs.
  - Otherwise: go to DATA_HI.
- DATA_HI accept: latch the byte as the high byte.
- DATA_LO accept:
  - Register `{hi, lo}` into `wr_data` and the word index into `wr_addr`.
  - Pulse `wr_en` for one cycle.
  - Increment the index.
  - Return to DATA_HI, or exit after word N.
- Word index: starts at 0 on every load. It never wraps, because N ≤ MAX_WORDS.
- `cpu_reset`: 1 in every state except DONE.
- `done`: 1 only in DONE.
- `err`: 1 only in ERR.
- DONE and ERR hold until `load_req` or reset. A `load_req` in any other state is ignored.

## Timing

- Reset values:
  - State: IDLE.
  - `rx_ready`, `wr_en`, `done`, `err`: 0.
  - `wr_addr`, `wr_data`: 0.
  - `cpu_reset`: 1.
- Reset asserted mid-load aborts immediately. Words already written stay in RAM, and `cpu_reset` stays high.
- `wr_en` is high for exactly one cycle, namely the cycle after the DATA_LO handshake. `wr_addr` and `wr_data` are valid during that cycle and hold their values afterwards.
- Last word without checksum:
  - `done` rises, and `cpu_reset` falls, one cycle after the final `wr_en` pulse (two cycles after the final byte handshake).
  - The RAM write therefore completes before the CPU is released.
- Checksum path: `done` or `err` rises one cycle after the CSUM_LO handshake.
- Throughput: one byte per cycle. Back-to-back `rx_valid` is fully supported.
- Single clock domain. Any synchronisation of `rx_*` is the source's responsibility.

## Configuration

- `ROM_LOADER_CHECKSUM_EN` defined:
  - After the N data words, states CSUM_HI/CSUM_LO accept a 16-bit checksum.
  - The expected value is the sum of all N data words, modulo 2^16, with the accumulator cleared at HDR_HI.
  - Match → DONE. Mismatch → ERR.
  - For N = 0 the expected checksum is 0x0000.
- Not defined:
  - No checksum states and no accumulator logic.
  - DONE follows the last data word directly, or HDR_LO when N = 0.

## Test plan

- Reset, then stream 00 03 / 00 05 / EC 10 / 00 07 → `wr_en` pulses at addresses 0,1,2 with data 0x0005, 0xEC10, 0x0007. `done`=1 and `cpu_reset`=0 one cycle after the third pulse.
- Stream header 80 01 (N = 32769) with MAX_WORDS=32768 → `err`=1 after the second byte, no `wr_en` pulse, `rx_ready`=0, `cpu_reset`=1.
- Stream 00 00 (checksum disabled) → DONE two cycles after the second byte, no writes.
- With `ROM_LOADER_CHECKSUM_EN`: stream 00 02 / 00 05 / EC 10 / EC 15 → DONE. The same stream with checksum EC 16 → ERR, with both words already written.
- `rx_valid` toggling randomly while `rx_ready` is 0 in DONE → no state change. Then pulse `load_req` → `cpu_reset`=1, and a second image reloads starting from address 0.
- Assert `rst_n`=0 after two data words of a five-word image → all outputs return to their reset values asynchronously, and a fresh header is accepted after release.
